ski_heap_arbiter: RTL and testbench
===================================

SKI_HEAP_ARBITER -- requirements
Module: ski_heap_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 10: heap cell address width.
REQ-002 SHALL have parameter DATA_W, default 64: heap cell data width.
REQ-003 SHALL have port system1000  input  1  single clock; all state on its rising edge.
REQ-004 SHALL have port system1000_rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports req_valid  input  2, and req_ready  output  2: per-requester handshake; bit 0 is the reduction engine, bit 1 is the host loader.
REQ-006 SHALL have ports req_we  input  2, and req_lock  input  2: per-requester write enable and lock-hold flag.
REQ-007 SHALL have ports req0_addr and req1_addr  input  ADDR_W, and req0_wdata and req1_wdata  input  DATA_W: per-requester address and write data.
REQ-008 SHALL have ports rsp_valid  output  2, and rsp_data  output  DATA_W: read response and its shared data.
REQ-009 SHALL have ports mem_en, mem_we  output  1; mem_addr  output  ADDR_W; mem_wdata  output  DATA_W: single-port heap RAM command.
REQ-010 SHALL have port mem_rdata  input  DATA_W: RAM read data, valid exactly 1 cycle after a read command.
REQ-011 SHALL have port conflict_cnt  output  16: saturating count of contention cycles.

Function
REQ-012 SHALL accept at most one transaction per cycle; accept[i] = req_valid[i] & req_ready[i].
REQ-013 SHALL drive req_ready combinationally: at most one bit high per cycle, and never high for a requester with req_valid low.
REQ-014 SHALL hold a 2-state lock FSM: UNLOCKED, LOCKED(owner).
REQ-015 In UNLOCKED, a single valid requester SHALL be granted; when both are valid, the requester other than last_grant SHALL be granted (round-robin).
REQ-016 In LOCKED(owner), only the owner SHALL be granted; the other requester SHALL stall regardless of owner idle cycles.
REQ-017 Acceptance with req_lock[i]=1 SHALL enter or stay in LOCKED(i); acceptance by the owner with req_lock=0 SHALL return the FSM to UNLOCKED on the next cycle.
REQ-018 last_grant SHALL update to i on every accept[i] and is otherwise held.
REQ-019 mem_en SHALL equal the OR of accept; mem_we, mem_addr and mem_wdata SHALL be muxed combinationally from the accepted requester; all SHALL be 0 when nothing is accepted.
REQ-020 A read accepted from requester i in cycle N SHALL produce rsp_valid[i]=1 for exactly cycle N+1, with rsp_data=mem_rdata; writes SHALL produce no response.
REQ-021 rsp_valid SHALL be a registered one-hot-or-zero tag; rsp_data SHALL pass mem_rdata through when rsp_valid is nonzero and be 0 otherwise.
REQ-022 Back-to-back reads SHALL sustain 1 transaction per cycle with no bubbles.
REQ-023 conflict_cnt SHALL increment in any cycle where a requester has req_valid=1 and req_ready=0, and SHALL saturate at 0xFFFF with no wrap.
REQ-024 A request in the same cycle as a lock release SHALL still be arbitrated under LOCKED; the other requester becomes eligible from the next cycle.

Reset
REQ-025 While system1000_rst=1, the block SHALL hold: FSM=UNLOCKED, last_grant=1 (requester 0 wins the first tie), rsp_valid=0, conflict_cnt=0, req_ready=0, mem_en=0.
REQ-026 Asserting reset mid-operation SHALL discard any pending read response (no rsp_valid after reset) and release any lock.
REQ-027 The first arbitration SHALL occur on the first rising edge after reset deasserts.

Verification
REQ-028 Both requesters valid, reading addresses 0x010 and 0x020 continuously, lock=0 -> grants alternate 0,1,0,1 starting with 0; rsp_valid alternates 01,10 one cycle later; conflict_cnt increments every cycle.
REQ-029 Requester 0 issues read 0x005 (lock=1), write 0x005 (lock=1), write 0x006 (lock=0), while requester 1 is valid throughout -> requester 1 stalls for all three transactions and is granted in the 4th cycle; conflict_cnt=3.
REQ-030 Write 0xDEADBEEF to 0x3FF from requester 1, then read 0x3FF from requester 0 -> mem_we=1 then 0; rsp_valid=01 with rsp_data=0xDEADBEEF one cycle after the read.
REQ-031 Requester 1 locks with a read, then reset is asserted in the response cycle -> rsp_valid=0 and FSM UNLOCKED; after release, requester 0 alone is granted immediately.
REQ-032 Force requester 1 to stall 70000 cycles under a requester-0 lock -> conflict_cnt holds at 0xFFFF without wrapping.

Source files
------------

// File: rtl/ski_heap_arbiter_if.sv
// Bus bundle for the heap arbiter: two requester ports, read response,
// single-port RAM command/read-data, and the contention counter.
interface ski_heap_arbiter_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 64
);
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0]        req_we;
  logic [1:0]        req_lock;
  logic [ADDR_W-1:0] req0_addr;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic [DATA_W-1:0] req1_wdata;
  logic [1:0]        rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [15:0]       conflict_cnt;

  // Requesters plus RAM model side.
  modport master (
    output req_valid, req_we, req_lock, req0_addr, req1_addr,
           req0_wdata, req1_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_data, mem_en, mem_we, mem_addr,
           mem_wdata, conflict_cnt
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_we, req_lock, req0_addr, req1_addr,
           req0_wdata, req1_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_data, mem_en, mem_we, mem_addr,
           mem_wdata, conflict_cnt
  );
endinterface

// File: rtl/ski_heap_arbiter.sv
// Two-requester arbiter for a single-port heap RAM: round-robin grant with
// a lock that lets one requester hold the RAM across several transactions,
// one-cycle read response routing, and a saturating contention counter.
module ski_heap_arbiter #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 64
) (
  input logic             system1000,
  input logic             system1000_rst,
  ski_heap_arbiter_if.slave bus
);

  typedef enum logic {UNLOCKED, LOCKED} lock_state_t;

  lock_state_t state, state_nxt;
  logic        owner, owner_nxt;
  logic        last_grant;
  logic [1:0]  ready;
  logic [1:0]  accept;
  logic        grant_idx;

  logic              mem_en_c;
  logic              mem_we_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_wdata_c;
  logic [1:0]        rsp_valid_q;
  logic [15:0]       conflict_q;

  assign accept    = bus.req_valid & ready;
  assign grant_idx = accept[1];

  // Lock state register.
  always_ff @(posedge system1000 or posedge system1000_rst) begin
    if (system1000_rst) begin
      state <= UNLOCKED;
      owner <= 1'b0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
    end
  end

  // Next lock state: a locked accept claims or keeps the lock, an unlocked
  // accept by the owner releases it.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    if (accept != 2'b00) begin
      if (bus.req_lock[grant_idx]) begin
        state_nxt = LOCKED;
        owner_nxt = grant_idx;
      end else if (state == LOCKED && grant_idx == owner) begin
        state_nxt = UNLOCKED;
      end
    end
  end

  // Grant: owner only while locked, otherwise round-robin on a tie.
  // Gated by reset so nothing is granted while the block is held.
  always_comb begin
    ready = '0;
    if (!system1000_rst) begin
      unique case (state)
        UNLOCKED: begin
          if (bus.req_valid == 2'b11) ready = last_grant ? 2'b01 : 2'b10;
          else                        ready = bus.req_valid;
        end
        LOCKED: begin
          ready = owner ? {bus.req_valid[1], 1'b0} : {1'b0, bus.req_valid[0]};
        end
        default: ready = '0;
      endcase
    end
  end

  // Last winner, used to break the next tie.
  always_ff @(posedge system1000 or posedge system1000_rst) begin
    if (system1000_rst)        last_grant <= 1'b1;
    else if (accept != 2'b00)  last_grant <= grant_idx;
  end

  // RAM command muxed from the accepted requester, all-zero when idle.
  always_comb begin
    mem_en_c    = 1'b0;
    mem_we_c    = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    if (accept[0]) begin
      mem_en_c    = 1'b1;
      mem_we_c    = bus.req_we[0];
      mem_addr_c  = bus.req0_addr;
      mem_wdata_c = bus.req0_wdata;
    end else if (accept[1]) begin
      mem_en_c    = 1'b1;
      mem_we_c    = bus.req_we[1];
      mem_addr_c  = bus.req1_addr;
      mem_wdata_c = bus.req1_wdata;
    end
  end

  // Response tag: one cycle after an accepted read, matching RAM latency.
  always_ff @(posedge system1000 or posedge system1000_rst) begin
    if (system1000_rst) rsp_valid_q <= '0;
    else                rsp_valid_q <= accept & ~bus.req_we;
  end

  // Saturating count of cycles in which some valid requester was stalled.
  always_ff @(posedge system1000 or posedge system1000_rst) begin
    if (system1000_rst)
      conflict_q <= '0;
    else if ((bus.req_valid & ~ready) != 2'b00 && conflict_q != '1)
      conflict_q <= conflict_q + 16'd1;
  end

  // Drive interface outputs; read data is forced to zero without a response.
  always_comb begin
    bus.req_ready    = ready;
    bus.mem_en       = mem_en_c;
    bus.mem_we       = mem_we_c;
    bus.mem_addr     = mem_addr_c;
    bus.mem_wdata    = mem_wdata_c;
    bus.rsp_valid    = rsp_valid_q;
    bus.rsp_data     = (rsp_valid_q != 2'b00) ? bus.mem_rdata : '0;
    bus.conflict_cnt = conflict_q;
  end

endmodule

// File: tb/tb_ski_heap_arbiter.sv
// Self-checking bench for ski_heap_arbiter: directed scenarios with expected
// grants per cycle, a scoreboard queue of expected read responses, a RAM
// model with one-cycle read latency, and a saturating conflict-count model.
module tb_ski_heap_arbiter;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 64;

  typedef struct {
    logic [1:0]        tag;
    logic [DATA_W-1:0] data;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  ski_heap_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ski_heap_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .system1000     (clk),
    .system1000_rst (rst),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] ram    [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] shadow [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rdata_q = '0;

  // RAM model: write or one-cycle-latency read on mem_en.
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            rdata_q <= ram[bus.mem_addr];
    end
  end
  assign bus.mem_rdata = rdata_q;

  rsp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned exp_cnt  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic push_idle();
    rsp_t e;
    e.tag  = 2'b00;
    e.data = '0;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] we, input logic [1:0] lk,
                       input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                       input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1);
    bus.req_valid  = v;
    bus.req_we     = we;
    bus.req_lock   = lk;
    bus.req0_addr  = a0;
    bus.req1_addr  = a1;
    bus.req0_wdata = d0;
    bus.req1_wdata = d1;
  endtask

  // One cycle: drive, check combinational grant/command and the response
  // due from the previous cycle, then record what this cycle should cause.
  task automatic step(input logic [1:0] v, input logic [1:0] we, input logic [1:0] lk,
                      input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                      input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                      input logic [1:0] exp_rdy);
    rsp_t              e;
    logic              ewe;
    logic [ADDR_W-1:0] eaddr;
    logic [DATA_W-1:0] ewd;
    @(negedge clk);
    drive(v, we, lk, a0, a1, d0, d1);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check("rsp_valid", {62'd0, bus.rsp_valid}, {62'd0, e.tag});
      check("rsp_data", bus.rsp_data, e.data);
    end
    ewe   = 1'b0;
    eaddr = '0;
    ewd   = '0;
    if (exp_rdy[0]) begin
      ewe = we[0]; eaddr = a0; ewd = d0;
    end else if (exp_rdy[1]) begin
      ewe = we[1]; eaddr = a1; ewd = d1;
    end
    check("req_ready", {62'd0, bus.req_ready}, {62'd0, exp_rdy});
    check("mem_en", {63'd0, bus.mem_en}, {63'd0, exp_rdy != 2'b00});
    check("mem_we", {63'd0, bus.mem_we}, {63'd0, ewe});
    check("mem_addr", {54'd0, bus.mem_addr}, {54'd0, eaddr});
    check("mem_wdata", bus.mem_wdata, ewd);
    check("conflict_cnt", {48'd0, bus.conflict_cnt}, {32'd0, exp_cnt});
    e.tag  = (exp_rdy & ~we);
    e.data = (e.tag != 2'b00) ? shadow[eaddr] : '0;
    sb.push_back(e);
    if (exp_rdy != 2'b00 && ewe) shadow[eaddr] = ewd;
    if ((v & ~exp_rdy) != 2'b00 && exp_cnt < 32'hFFFF) exp_cnt++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(2'b11, 2'b00, 2'b00, 10'h001, 10'h002, 64'd0, 64'd0);
    #1;
    check("rst_ready", {62'd0, bus.req_ready}, 64'd0);
    check("rst_mem_en", {63'd0, bus.mem_en}, 64'd0);
    check("rst_rsp_valid", {62'd0, bus.rsp_valid}, 64'd0);
    check("rst_cnt", {48'd0, bus.conflict_cnt}, 64'd0);
    repeat (2) @(negedge clk);
    drive(2'b00, 2'b00, 2'b00, '0, '0, '0, '0);
    rst = 1'b0;
    sb.delete();
    push_idle();
    exp_cnt = 0;
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      ram[i]    = 64'h1234_5678_0000_0000 | (64'(i) * 64'h0001_0001);
      shadow[i] = 64'h1234_5678_0000_0000 | (64'(i) * 64'h0001_0001);
    end
    drive(2'b00, 2'b00, 2'b00, '0, '0, '0, '0);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Round-robin under full contention, first tie won by requester 0.
    do_reset();
    for (int i = 0; i < 8; i++)
      step(2'b11, 2'b00, 2'b00, 10'h010, 10'h020, 64'hAAAA, 64'hBBBB,
           (i % 2 == 0) ? 2'b01 : 2'b10);
    step(2'b00, 2'b00, 2'b00, '0, '0, '0, '0, 2'b00);

    // Lock held by requester 0 over three transactions; release cycle still locked.
    do_reset();
    step(2'b11, 2'b00, 2'b01, 10'h005, 10'h020, 64'h0, 64'h0, 2'b01);
    step(2'b11, 2'b01, 2'b01, 10'h005, 10'h020, 64'h5555_0005, 64'h0, 2'b01);
    step(2'b11, 2'b01, 2'b00, 10'h006, 10'h020, 64'h6666_0006, 64'h0, 2'b01);
    step(2'b10, 2'b00, 2'b00, 10'h000, 10'h020, 64'h0, 64'h0, 2'b10);
    step(2'b01, 2'b00, 2'b00, 10'h005, 10'h000, 64'h0, 64'h0, 2'b01);
    step(2'b00, 2'b00, 2'b00, '0, '0, '0, '0, 2'b00);
    check("lock_cnt", {48'd0, bus.conflict_cnt}, 64'd3);

    // Write top address from requester 1, read it back from requester 0.
    do_reset();
    step(2'b10, 2'b10, 2'b00, 10'h000, 10'h3FF, 64'h0, 64'hDEAD_BEEF, 2'b10);
    step(2'b01, 2'b00, 2'b00, 10'h3FF, 10'h000, 64'h0, 64'h0, 2'b01);
    step(2'b00, 2'b00, 2'b00, '0, '0, '0, '0, 2'b00);
    check("wr_rd_data_seen", shadow[10'h3FF], 64'hDEAD_BEEF);

    // Reset during the response cycle of a locked read.
    do_reset();
    step(2'b10, 2'b00, 2'b10, 10'h000, 10'h030, 64'h0, 64'h0, 2'b10);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_rsp_valid", {62'd0, bus.rsp_valid}, 64'd0);
    check("midrst_rsp_data", bus.rsp_data, 64'd0);
    do_reset();
    step(2'b01, 2'b00, 2'b00, 10'h040, 10'h000, 64'h0, 64'h0, 2'b01);
    step(2'b00, 2'b00, 2'b00, '0, '0, '0, '0, 2'b00);

    // Long stall under a requester-0 lock saturates the counter.
    do_reset();
    step(2'b01, 2'b00, 2'b01, 10'h050, 10'h000, 64'h0, 64'h0, 2'b01);
    step(2'b10, 2'b00, 2'b00, 10'h000, 10'h060, 64'h0, 64'h0, 2'b00);
    repeat (69999) @(posedge clk);
    exp_cnt = (exp_cnt + 69999 > 32'hFFFF) ? 32'hFFFF : exp_cnt + 69999;
    step(2'b11, 2'b01, 2'b00, 10'h050, 10'h060, 64'h0505, 64'h0, 2'b01);
    step(2'b10, 2'b00, 2'b00, 10'h000, 10'h060, 64'h0, 64'h0, 2'b10);
    step(2'b00, 2'b00, 2'b00, '0, '0, '0, '0, 2'b00);
    check("sat_cnt", {48'd0, bus.conflict_cnt}, 64'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
